// File: rtl/round_pkg.sv
// Shared types and constants for the round sequencer.
// The state encoding is visible on the round_sequencer state port.
package round_pkg;

  localparam int ROUND_W           = 8;
  localparam int MAX_ROUND_DEFAULT = 100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHOW    = 3'd1,
    ST_PLAY    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  // Bits needed to hold n-1 (the largest value a countdown is loaded with).
  // At least one bit, so that a one-cycle countdown still has a counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter. It stops at zero and raises zero while it holds
// zero. load takes priority over counting.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         count_en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load on request; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer for a multi-round game.
// The sequence is IDLE -> SHOW (the round number is announced) -> PLAY ->
// ADVANCE -> SHOW ..., and the game ends in OVER.
// round_num feeds the three-digit display decoder directly.
// Build option: define ROUND_TIMEOUT_EN to limit each PLAY round to
// TIMEOUT_CYCLES clocks. When the limit runs out, the round counts as a fail.
module round_sequencer
  import round_pkg::*;
#(
  parameter int MAX_ROUND      = MAX_ROUND_DEFAULT,
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pass,
  input  logic               fail,
  output logic [ROUND_W-1:0] round_num,
  output logic [2:0]         state,
  output logic               play_en,
  output logic               game_over,
  output logic               won
);

  // One width serves both timers. It is sized for the larger cycle parameter.
  localparam int CNT_MAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0]   SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [ROUND_W-1:0] LAST      = ROUND_W'(MAX_ROUND);

  state_t             state_q, state_next;
  logic [ROUND_W-1:0] round_q, round_next;
  logic               won_next;
  logic               show_load, show_zero;
  logic               play_load, play_zero;

  cycle_timer #(.W(CNT_W)) u_show_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (show_load),
    .load_value (SHOW_LOAD),
    .count_en   (state_q == ST_SHOW),
    .zero       (show_zero)
  );

`ifdef ROUND_TIMEOUT_EN
  localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  cycle_timer #(.W(CNT_W)) u_play_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (play_load),
    .load_value (PLAY_LOAD),
    .count_en   (state_q == ST_PLAY),
    .zero       (play_zero)
  );
`else
  // Without the timeout build, PLAY never expires.
  assign play_zero = 1'b0;
`endif

  // Next state, next round and timer loads. Each timer loads on the clock
  // that enters its state.
  always_comb begin
    state_next = state_q;
    round_next = round_q;
    won_next   = won;
    show_load  = 1'b0;
    play_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SHOW;
          round_next = ROUND_W'(1);
          show_load  = 1'b1;
        end
      end
      ST_SHOW: begin
        if (show_zero) begin
          state_next = ST_PLAY;
          play_load  = 1'b1;
        end
      end
      ST_PLAY: begin
        // fail takes priority over pass. pass takes priority over expiry.
        if (fail) begin
          state_next = ST_OVER;
          won_next   = 1'b0;
        end else if (pass) begin
          state_next = ST_ADVANCE;
        end else if (play_zero) begin
          state_next = ST_OVER;
          won_next   = 1'b0;
        end
      end
      ST_ADVANCE: begin
        // Using >= keeps round_num from ever passing MAX_ROUND.
        if (round_q >= LAST) begin
          state_next = ST_OVER;
          won_next   = 1'b1;
        end else begin
          state_next = ST_SHOW;
          round_next = round_q + 1'b1;
          show_load  = 1'b1;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_next = ST_SHOW;
          round_next = ROUND_W'(1);
          won_next   = 1'b0;
          show_load  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        round_next = '0;
        won_next   = 1'b0;
      end
    endcase
  end

  // State and registered outputs. The flags are decoded from the next state
  // so that they change on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      round_q   <= '0;
      play_en   <= 1'b0;
      game_over <= 1'b0;
      won       <= 1'b0;
    end else begin
      state_q   <= state_next;
      round_q   <= round_next;
      play_en   <= (state_next == ST_PLAY);
      game_over <= (state_next == ST_OVER);
      won       <= won_next;
    end
  end

  assign state     = state_q;
  assign round_num = round_q;

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 The module SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 Parameter MAX_ROUND, default 100, is the final round number; legal range 1..100.
REQ-003 Parameter SHOW_CYCLES, default 50_000_000, is the number of clocks the round number is announced before play.
REQ-004 Parameter TIMEOUT_CYCLES, default 500_000_000, is the clocks allowed per round (timeout build only).
REQ-005 Port: clk  in  1  system clock.
REQ-006 Port: rst  in  1  asynchronous active-high reset.
REQ-007 Port: start  in  1  one-cycle pulse; begins a game from IDLE or OVER.
REQ-008 Port: pass  in  1  one-cycle pulse; player completed the current round.
REQ-009 Port: fail  in  1  one-cycle pulse; player failed the current round.
REQ-010 Port: round_num  out  8  current round, 0..MAX_ROUND; drives the 3-digit display.
REQ-011 Port: state  out  3  encoded FSM state (package enum).
REQ-012 Port: play_en  out  1  high only while in PLAY.
REQ-013 Port: game_over  out  1  high while in OVER.
REQ-014 Port: won  out  1  high in OVER only if round MAX_ROUND was passed.

Function
REQ-015 The FSM SHALL have states IDLE, SHOW, PLAY, ADVANCE, OVER.
REQ-016 IDLE: round_num=0; start -> SHOW with round_num=1 on the next clock.
REQ-017 SHOW: a down-counter loaded with SHOW_CYCLES-1 on entry; at zero -> PLAY; pass/fail ignored.
REQ-018 PLAY: pass -> ADVANCE; fail -> OVER with won=0; start ignored.
REQ-019 pass and fail in the same PLAY cycle: fail wins.
REQ-020 ADVANCE (one cycle): round_num==MAX_ROUND -> OVER with won=1; otherwise round_num+1 and -> SHOW.
REQ-021 round_num SHALL never exceed MAX_ROUND; no wrap-around under any input sequence.
REQ-022 OVER: round_num holds its final value; start -> SHOW with round_num=1 and won cleared.
REQ-023 Outputs SHALL be registered; play_en and game_over change on the same edge as state.
REQ-024 Counter width SHALL be $clog2 of the largest cycle parameter, no overflow at parameter maximum.

Reset
REQ-025 On rst: state=IDLE, round_num=0, play_en=0, game_over=0, won=0, counters=0, asynchronously.
REQ-026 Reset asserted mid-SHOW or mid-PLAY SHALL abandon the game; no pulse is remembered after release.
REQ-027 First start SHALL be accepted on the first clock edge after rst deasserts.

Configuration
REQ-028 Macro ROUND_TIMEOUT_EN: when defined, a PLAY counter loads TIMEOUT_CYCLES-1 on PLAY entry and reaching zero without pass is treated as fail (-> OVER, won=0); pass on the expiry cycle wins.
REQ-029 Without ROUND_TIMEOUT_EN: no timeout counter is synthesised; PLAY waits indefinitely; TIMEOUT_CYCLES is unused.

Structure
REQ-030 Package round_pkg SHALL hold the state enum type, ROUND_W=8, and default MAX_ROUND constant.
REQ-031 One sub-module, cycle_timer (load, count-down, zero flag), SHALL be instantiated for SHOW and, when enabled, for timeout.
REQ-032 round_num connects directly to the existing three-digit display decoder; no BCD conversion in this block.

Verification (SHOW_CYCLES=4, TIMEOUT_CYCLES=10, MAX_ROUND=3)
REQ-033 Reset then start -> round_num=1, state SHOW for 4 clocks, then PLAY with play_en=1.
REQ-034 pass in each PLAY for rounds 1..3 -> round_num 1,2,3 then OVER, won=1, round_num stays 3.
REQ-035 fail in round 2 -> OVER next clock, won=0, round_num=2; start -> round_num=1, SHOW.
REQ-036 pass and fail same cycle in round 1 -> OVER, won=0.
REQ-037 ROUND_TIMEOUT_EN defined, no pass for 10 PLAY clocks -> OVER, won=0; undefined -> still PLAY after 1000 clocks.
REQ-038 rst asserted mid-PLAY round 2 -> all outputs reset immediately; pass while in rst ignored.
